// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply / multiply-accumulate / divide unit with HI/LO
// result registers.
//   clk, rst     : single clock; asynchronous active-high reset
//   start, op    : request and opcode (0 MULT, 1 MULTU, 2 MADD, 3 MADDU,
//                  4 DIV, 5 DIVU, 6 MTHI, 7 MTLO); start is sampled only in IDLE
//   a, b         : operands (a also carries MTHI/MTLO data)
//   busy         : high while iterating
//   done         : one-cycle completion pulse
//   hi, lo       : HI/LO registers
//   div_by_zero  : qualified by done; set for DIV/DIVU with b = 0
// A multiply or divide takes WIDTH iterations, one bit per cycle. Signed ops
// iterate on magnitudes, and the sign is fixed up when HI/LO are written.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [2:0]       op_q;
   logic             neg_q;     // sign of product / quotient
   logic             neg_r_q;   // sign of remainder (dividend sign)
   logic [WIDTH-1:0] opnd_q;    // multiplicand magnitude or divisor magnitude
   logic [WIDTH-1:0] acc_hi;    // partial product high half / partial remainder
   logic [WIDTH-1:0] acc_lo;    // multiplier / dividend, shifted out one bit per step
   logic [CW-1:0]    cnt;
   logic             dbz_q;

   // request decode on the live inputs
   logic             is_mt_in, is_div_in, signed_in, sa, sb, accept, dbz_in;
   logic [WIDTH-1:0] mag_a, mag_b;

   assign is_mt_in  = op[2] & op[1];
   assign is_div_in = (op == 3'd4) || (op == 3'd5);
   assign signed_in = (op == 3'd0) || (op == 3'd2) || (op == 3'd4);
   assign sa        = signed_in & a[WIDTH-1];
   assign sb        = signed_in & b[WIDTH-1];
   assign mag_a     = sa ? -a : a;
   assign mag_b     = sb ? -b : b;
   assign accept    = (state == IDLE) && start && !is_mt_in;
   assign dbz_in    = is_div_in && (b == '0);

   logic q_is_div, q_is_madd;
   assign q_is_div  = op_q[2];
   assign q_is_madd = (op_q == 3'd2) || (op_q == 3'd3);

   // one iteration step
   logic [WIDTH:0]   sum, rem_sh, diff;
   logic [WIDTH-1:0] hi_nx, lo_nx;

   always_comb begin
      sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
      rem_sh = {acc_hi, acc_lo[WIDTH-1]};
      diff   = rem_sh - {1'b0, opnd_q};
      if (q_is_div) begin
         // restoring divide: keep the subtraction only if it did not borrow
         if (!diff[WIDTH]) begin
            hi_nx = diff[WIDTH-1:0];
            lo_nx = {acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_nx = rem_sh[WIDTH-1:0];
            lo_nx = {acc_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         // shift-add: the carry out of the add becomes the new top bit
         hi_nx = sum[WIDTH:1];
         lo_nx = {sum[0], acc_lo[WIDTH-1:1]};
      end
   end

   // final result, used only on the last step
   logic [2*WIDTH-1:0] prod, prod_s, mac;
   logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

   always_comb begin
      prod   = {hi_nx, lo_nx};
      prod_s = neg_q ? -prod : prod;
      // hi/lo still hold their start-of-op values here, as MADD needs
      mac    = prod_s + (q_is_madd ? {hi, lo} : '0);
      quo    = neg_q   ? -lo_nx : lo_nx;
      rem    = neg_r_q ? -hi_nx : hi_nx;
      if (q_is_div) begin
         res_hi = rem;
         res_lo = quo;
      end else begin
         res_hi = mac[2*WIDTH-1:WIDTH];
         res_lo = mac[WIDTH-1:0];
      end
   end

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = dbz_in ? DONE : RUN;
         RUN:     if (cnt == LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy        = (state == RUN);
      done        = (state == DONE);
      div_by_zero = (state == DONE) && dbz_q;
   end

   // datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q    <= '0;
         neg_q   <= 1'b0;
         neg_r_q <= 1'b0;
         opnd_q  <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         cnt     <= '0;
         dbz_q   <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && is_mt_in) begin
                  if (op[0]) lo <= a;
                  else       hi <= a;
               end else if (accept) begin
                  op_q    <= op;
                  neg_q   <= sa ^ sb;
                  neg_r_q <= sa;
                  opnd_q  <= is_div_in ? mag_b : mag_a;
                  acc_hi  <= '0;
                  acc_lo  <= is_div_in ? mag_a : mag_b;
                  cnt     <= '0;
                  dbz_q   <= dbz_in;
               end
            end
            RUN: begin
               acc_hi <= hi_nx;
               acc_lo <= lo_nx;
               cnt    <= cnt + CW'(1);
               if (cnt == LAST) begin
                  hi <= res_hi;
                  lo <= res_lo;
               end
            end
            DONE:    dbz_q <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32): the stimulus pushes hand-computed
// results, and a monitor pops and compares them on every done pulse.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          busy;
      string       name;
   } exp_t;

   exp_t sb[$];
   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   int busy_cnt = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // monitor
   always @(negedge clk) begin
      if (rst) begin
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (!done) chk("dbz_idle", {63'd0, div_by_zero}, 64'd0);
         if (done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
               chk("unexpected_done", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk({e.name, "_hi"},   {32'd0, hi}, {32'd0, e.hi});
               chk({e.name, "_lo"},   {32'd0, lo}, {32'd0, e.lo});
               chk({e.name, "_dbz"},  {63'd0, div_by_zero}, {63'd0, e.dbz});
               chk({e.name, "_busy"}, 64'(busy_cnt), 64'(e.busy));
            end
            busy_cnt = 0;
         end
      end
   end

   task automatic run_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed,
                         input int eb, input string nm, input bit poke);
      exp_t e;
      int   d0;
      bit   seen;
      e.hi = eh; e.lo = el; e.dbz = ed; e.busy = eb; e.name = nm;
      sb.push_back(e);
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b1; op = o; a = aa; b = bb;
      @(negedge clk);
      // operands scrambled after the start edge must not matter
      start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
      if (poke) begin
         repeat (10) @(negedge clk);
         start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd5;
         @(negedge clk);
         start = 1'b0;
      end
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk) #1;
         seen = (done_cnt != d0);
      end
      if (!seen) chk({nm, "_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic mt(input logic [2:0] o, input logic [31:0] data);
      @(negedge clk);
      start = 1'b1; op = o; a = data; b = 32'd0;
      @(negedge clk);
      start = 1'b0;
      #1;
   endtask

   initial begin
      int d0;
      rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
      #1;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      run_op(3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 32, "mult_neg", 1'b0);
      d0 = done_cnt;
      run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 32, "multu_max", 1'b1);
      repeat (40) @(negedge clk);
      #1;
      chk("multu_single_done", 64'(done_cnt - d0), 64'd1);

      d0 = done_cnt;
      mt(3'd6, 32'd0);
      chk("mthi_hi", {32'd0, hi}, 64'd0);
      chk("mthi_lo_kept", {32'd0, lo}, 64'd1);
      mt(3'd7, 32'd10);
      chk("mtlo_lo", {32'd0, lo}, 64'd10);
      repeat (3) @(negedge clk);
      #1;
      chk("mt_no_done", 64'(done_cnt - d0), 64'd0);

      run_op(3'd2, 32'd3, 32'd4, 32'd0, 32'd22, 1'b0, 32, "madd_pos", 1'b0);
      run_op(3'd2, 32'hFFFFFFFF, 32'd23, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32, "madd_neg", 1'b0);
      run_op(3'd0, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd0, 32'd6, 1'b0, 32, "mult_negneg", 1'b0);
      mt(3'd7, 32'h80000000);
      run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h80000001, 1'b0, 32, "maddu_max", 1'b0);
      run_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32, "div_negdvd", 1'b0);
      run_op(3'd4, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 32, "div_negdvs", 1'b0);
      run_op(3'd5, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 32, "divu", 1'b0);
      run_op(3'd5, 32'd7, 32'd0, 32'd1, 32'd3, 1'b1, 0, "divu_zero", 1'b0);
      run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 32, "div_wrap", 1'b0);

      // reset mid-MULT: outputs clear without a clock edge, no done afterwards
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_hilo", {hi, lo}, 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      #1;
      chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

      run_op(3'd1, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 32, "multu_after_rst", 1'b0);
      repeat (3) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter SHALL be: WIDTH, 32, operand and HI/LO register width (8..64).
REQ-002 Port SHALL be: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port SHALL be: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port SHALL be: start  input  1  request; sampled only in IDLE.
REQ-005 Port SHALL be: op  input  3  0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 DIV, 5 DIVU, 6 MTHI, 7 MTLO.
REQ-006 Port SHALL be: a  input  WIDTH  operand A / dividend / MTHI-MTLO data.
REQ-007 Port SHALL be: b  input  WIDTH  operand B / divisor.
REQ-008 Port SHALL be: busy  output  1  high while iterating (RUN).
REQ-009 Port SHALL be: done  output  1  one-cycle completion pulse.
REQ-010 Port SHALL be: hi  output  WIDTH  HI register.
REQ-011 Port SHALL be: lo  output  WIDTH  LO register.
REQ-012 Port SHALL be: div_by_zero  output  1  valid only while done=1; high for DIV/DIVU with b=0.

Function
REQ-013 FSM SHALL have states IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-014 IDLE, start=1, op=6/7: hi (MTHI) or lo (MTLO) SHALL be written with a at that edge; FSM stays IDLE; no done pulse.
REQ-015 IDLE, start=1, op 0-5: a, b, op SHALL be latched at that edge (E0); FSM -> RUN, iteration counter = 0.
REQ-016 RUN SHALL perform exactly one shift-add (multiply) or restoring-subtract (divide) step per cycle for WIDTH cycles; FSM -> DONE at edge E_WIDTH.
REQ-017 hi/lo SHALL hold previous values through RUN and update only at edge E_WIDTH; done=1 in the following cycle; FSM -> IDLE at the next edge.
REQ-018 start in RUN or DONE SHALL be ignored (no queueing); a, b, op changes after E0 SHALL not affect the result.
REQ-019 Signed ops (MULT, MADD, DIV) SHALL iterate on magnitudes and apply sign correction when writing results.
REQ-020 MULT/MULTU: {hi,lo} SHALL = full 2*WIDTH-bit product, signed or unsigned respectively.
REQ-021 MADD/MADDU: {hi,lo} SHALL = old {hi,lo} + product, modulo 2^(2*WIDTH); old value = value at E0.
REQ-022 DIV/DIVU: lo SHALL = quotient truncated toward zero, hi SHALL = remainder with dividend's sign (DIV).
REQ-023 DIV with a = most-negative and b = -1: lo SHALL = most-negative (wrap), hi = 0, div_by_zero = 0.
REQ-024 DIV/DIVU with b = 0: FSM SHALL go IDLE -> DONE directly at E0 (done in next cycle), hi/lo unchanged, div_by_zero=1.
REQ-025 div_by_zero SHALL be 0 in every cycle where done=0.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0, regardless of clk.
REQ-027 rst asserted during RUN SHALL abort the operation with no done pulse; first start after rst release SHALL behave as from power-up.

Verification (WIDTH=32)
REQ-028 MULT a=0xFFFFFFFD, b=7 -> busy 32 cycles, done 1 cycle, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-029 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; start pulsed mid-RUN ignored, single done.
REQ-030 MTHI 0, MTLO 10, then MADD a=3, b=4 -> hi=0, lo=22; then MADD a=0xFFFFFFFF, b=23 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF.
REQ-031 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
REQ-032 DIVU a=7, b=0 -> done one cycle after start edge, div_by_zero=1, hi/lo unchanged; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 rst asserted 10 cycles into MULT -> busy, hi, lo = 0 without clock edge; no done pulse; following MULTU 5*6 -> lo=30, hi=0.
